// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes and the ALU operation codes driven on the ALU interface.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } stateT;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  // Supported opcodes other than R-type (R-type legality also needs Funct).
  function automatic logic isNonROp(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control-to-datapath bundle: instruction fields and Z flag in, enables and
// selects out. The control unit is the master side.
interface mips_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] AluOp;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Op, Funct, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, AluOp, PCSrc, PCEn, Illegal, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, AluOp, PCSrc, PCEn, Illegal, State
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct decoder: maps Funct to the ALU operation and flags
// unsupported funct codes.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] Funct,
  output logic [3:0] AluOp,
  output logic       FunctValid
);

  always_comb begin
    AluOp      = ALU_ADD;
    FunctValid = 1'b1;
    case (Funct)
      FN_ADD:  AluOp = ALU_ADD;
      FN_SUB:  AluOp = ALU_SUB;
      FN_AND:  AluOp = ALU_AND;
      FN_OR:   AluOp = ALU_OR;
      FN_XOR:  AluOp = ALU_XOR;
      FN_NOR:  AluOp = ALU_NOR;
      FN_SLT:  AluOp = ALU_SLT;
      default: FunctValid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction and
// driving the ALU operation plus every datapath enable and select.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  mips_ctrl_if.master     bus
);

  stateT      stateReg;
  logic [3:0] functAluOp;
  logic       functValid;

  mips_alu_decoder uAluDec (
    .Funct      (bus.Funct),
    .AluOp      (functAluOp),
    .FunctValid (functValid)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      stateReg <= stateT'(RESET_STATE);
    end else begin
      case (stateReg)
        S_FETCH:  stateReg <= S_DECODE;
        S_DECODE: begin
          case (bus.Op)
            OP_LW, OP_SW:   stateReg <= S_MEMADR;
            OP_R:           stateReg <= functValid ? S_EXECUTE : S_FETCH;
            OP_BEQ, OP_BNE: stateReg <= S_BRANCH;
            OP_ADDI:        stateReg <= S_ADDIEX;
            OP_J:           stateReg <= S_JUMP;
            default:        stateReg <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (bus.Op == OP_LW)      stateReg <= S_MEMRD;
          else if (bus.Op == OP_SW) stateReg <= S_MEMWR;
          else                      stateReg <= S_FETCH;
        end
        S_MEMRD:   stateReg <= S_MEMWB;
        S_EXECUTE: stateReg <= S_ALUWB;
        S_ADDIEX:  stateReg <= S_ADDIWB;
        default:   stateReg <= S_FETCH;
      endcase
    end
  end

  // Moore outputs; only AluOp (EXECUTE), PCEn (BRANCH) and Illegal (DECODE)
  // look at the instruction fields or the Z flag.
  always_comb begin
    bus.IorD     = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.AluOp    = ALU_ADD;
    bus.PCSrc    = 2'b00;
    bus.PCEn     = 1'b0;
    bus.Illegal  = 1'b0;
    bus.State    = stateReg;
    case (stateReg)
      S_FETCH: begin
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = 1'b1;
        bus.PCEn    = 1'b1;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        bus.Illegal = (bus.Op == OP_R) ? !functValid : !isNonROp(bus.Op);
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: bus.IorD = 1'b1;
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.AluOp   = functAluOp;
      end
      S_ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.AluOp   = ALU_SUB;
        bus.PCSrc   = 2'b01;
        bus.PCEn    = ((bus.Op == OP_BEQ) && bus.Zero) ||
                      ((bus.Op == OP_BNE) && !bus.Zero);
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_ADDIWB: bus.RegWrite = 1'b1;
      S_JUMP: begin
        bus.PCSrc = 2'b10;
        bus.PCEn  = 1'b1;
      end
      default: bus.State = stateReg;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: instruction-level reference model
// queues expected per-cycle control vectors; a monitor compares every cycle.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  mips_ctrl_if ctrlIf ();

  mips_multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .CLK     (clk),
    .RESET_N (resetN),
    .bus     (ctrlIf)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluOp;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic       illegal;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  passes = 0;
  int  cyc    = 0;
  bit  monOn  = 1'b0;
  expT gotV, expV;

  logic [5:0] legalFn[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b100110, 6'b100111, 6'b101010};
  logic [5:0] legalOp[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                             6'b000101, 6'b001000, 6'b000010};

  function automatic expT blank(input int st);
    expT e = '0;
    e.st = 4'(st);
    return e;
  endfunction

  // Reference ALU operation for an R-type funct; returns 1 if funct supported.
  function automatic bit rOp(input logic [5:0] fn, output logic [3:0] op);
    op = 4'b0000;
    case (fn)
      6'b100000: op = 4'b0000;
      6'b100010: op = 4'b0010;
      6'b100100: op = 4'b0100;
      6'b100101: op = 4'b0101;
      6'b100110: op = 4'b0110;
      6'b100111: op = 4'b0111;
      6'b101010: op = 4'b1010;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Build the instruction's cycle-by-cycle expectation, optionally cut short
  // by a 2-cycle reset asserted during cycle rstAt (-1 = no reset).
  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int rstAt);
    expT seq[$];
    expT e;
    logic [3:0] aop;
    bit fnOk;
    int n;
    fnOk = rOp(fn, aop);
    e = blank(0); e.irWrite = 1; e.aluSrcB = 2'b01; e.pcEn = 1; seq.push_back(e);
    e = blank(1); e.aluSrcB = 2'b11;
    e.illegal = (op == 6'b000000) ? !fnOk :
                !(op inside {6'b100011, 6'b101011, 6'b000100, 6'b000101,
                             6'b001000, 6'b000010});
    seq.push_back(e);
    if (op == 6'b100011) begin
      e = blank(2); e.aluSrcA = 1; e.aluSrcB = 2'b10; seq.push_back(e);
      e = blank(3); e.iorD = 1; seq.push_back(e);
      e = blank(4); e.memtoReg = 1; e.regWrite = 1; seq.push_back(e);
    end else if (op == 6'b101011) begin
      e = blank(2); e.aluSrcA = 1; e.aluSrcB = 2'b10; seq.push_back(e);
      e = blank(5); e.iorD = 1; e.memWrite = 1; seq.push_back(e);
    end else if (op == 6'b000000 && fnOk) begin
      e = blank(6); e.aluSrcA = 1; e.aluOp = aop; seq.push_back(e);
      e = blank(7); e.regDst = 1; e.regWrite = 1; seq.push_back(e);
    end else if (op == 6'b000100 || op == 6'b000101) begin
      e = blank(8); e.aluSrcA = 1; e.aluOp = 4'b0010; e.pcSrc = 2'b01;
      e.pcEn = (op == 6'b000100) ? z : !z;
      seq.push_back(e);
    end else if (op == 6'b001000) begin
      e = blank(9); e.aluSrcA = 1; e.aluSrcB = 2'b10; seq.push_back(e);
      e = blank(10); e.regWrite = 1; seq.push_back(e);
    end else if (op == 6'b000010) begin
      e = blank(11); e.pcSrc = 2'b10; e.pcEn = 1; seq.push_back(e);
    end
    if (rstAt >= seq.size()) rstAt = seq.size() - 1;
    if (rstAt >= 0) begin
      while (seq.size() > rstAt + 1) void'(seq.pop_back());
      e = blank(0); e.irWrite = 1; e.aluSrcB = 2'b01; e.pcEn = 1; seq.push_back(e);
    end
    n = seq.size();
    $display("txn op=%b fn=%b zero=%0d rstAt=%0d cycles=%0d", op, fn, z, rstAt, n);
    ctrlIf.Op    = op;
    ctrlIf.Funct = fn;
    ctrlIf.Zero  = z;
    foreach (seq[i]) expQ.push_back(seq[i]);
    if (rstAt < 0) begin
      repeat (n) @(posedge clk);
      #1;
    end else begin
      repeat (rstAt) @(posedge clk);
      #1 resetN = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetN = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      cyc++;
      gotV.st       = ctrlIf.State;
      gotV.iorD     = ctrlIf.IorD;
      gotV.memWrite = ctrlIf.MemWrite;
      gotV.irWrite  = ctrlIf.IRWrite;
      gotV.regDst   = ctrlIf.RegDst;
      gotV.memtoReg = ctrlIf.MemtoReg;
      gotV.regWrite = ctrlIf.RegWrite;
      gotV.aluSrcA  = ctrlIf.ALUSrcA;
      gotV.aluSrcB  = ctrlIf.ALUSrcB;
      gotV.aluOp    = ctrlIf.AluOp;
      gotV.pcSrc    = ctrlIf.PCSrc;
      gotV.pcEn     = ctrlIf.PCEn;
      gotV.illegal  = ctrlIf.Illegal;
      checks++;
      if (expQ.size() == 0) begin
        $display("FAIL queue_underflow cyc=%0d got state=%0d required=nothing queued",
                 cyc, gotV.st);
      end else begin
        expV = expQ.pop_front();
        if (gotV !== expV)
          $display("FAIL ctrl_vec cyc=%0d got state=%0d vec=%h required state=%0d vec=%h",
                   cyc, gotV.st, gotV, expV.st, expV);
        else
          passes++;
      end
    end
  end

  initial begin
    resetN       = 1'b0;
    ctrlIf.Op    = 6'b0;
    ctrlIf.Funct = 6'b0;
    ctrlIf.Zero  = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    monOn = 1'b1;

    issue(6'b100011, 6'b010101, 1'b0, -1);              // LW
    foreach (legalFn[i]) issue(6'b000000, legalFn[i], 1'($urandom_range(0, 1)), -1);
    issue(6'b000100, 6'b0, 1'b1, -1);                   // BEQ taken
    issue(6'b000100, 6'b0, 1'b0, -1);                   // BEQ not taken
    issue(6'b000101, 6'b0, 1'b0, -1);                   // BNE taken
    issue(6'b000101, 6'b0, 1'b1, -1);                   // BNE not taken
    issue(6'b111111, 6'b100000, 1'b0, -1);              // illegal opcode
    issue(6'b000000, 6'b000000, 1'b0, -1);              // illegal funct
    issue(6'b101011, 6'b0, 1'b0, -1);                   // SW
    issue(6'b000010, 6'b0, 1'b0, -1);                   // J
    issue(6'b001000, 6'b0, 1'b1, -1);                   // ADDI
    issue(6'b000100, 6'b0, 1'b1, 2);                    // reset while in BRANCH
    issue(6'b100011, 6'b0, 1'b0, 2);                    // reset while in MEMADR
    issue(6'b101011, 6'b0, 1'b0, 3);                    // reset while in MEMWR
    issue(6'b100011, 6'b0, 1'b0, 4);                    // reset while in MEMWB

    for (int k = 0; k < 300; k++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int rst;
      op  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legalOp[$urandom_range(0, 6)];
      fn  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legalFn[$urandom_range(0, 6)];
      rst = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      issue(op, fn, 1'($urandom_range(0, 1)), rst);
    end

    monOn = 1'b0;
    checks++;
    if (expQ.size() != 0)
      $display("FAIL queue_drain got %0d entries left required 0", expQ.size());
    else
      passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS control unit. It is the producer side of the ALU interface.
- Sequences each instruction through a Moore FSM and drives the 4-bit AluOp plus all datapath enables.
- Consumes the ALU Z flag to resolve beq/bne.
- Sits between the instruction register and the datapath (register file, memory mux, PC register, ALU).

Parameters:
- RESET_STATE, 4'd0, state encoding entered on reset (FETCH); kept as a parameter only for bench visibility, never overridden in the design.

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RESET_N  input  1  synchronous active-low reset, sampled on rising CLK
- Op  input  6  instruction[31:26] from the instruction register
- Funct  input  6  instruction[5:0] from the instruction register
- Zero  input  1  ALU Z output (result == 0)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register load enable
- RegDst  output  1  write register select: 0 = rt, 1 = rd
- MemtoReg  output  1  write-back data select: 0 = ALUOut, 1 = Data
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = rs value
- ALUSrcB  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- AluOp  output  4  ALU operation code
- PCSrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  output  1  PC register load enable
- Illegal  output  1  one-cycle pulse in DECODE when Op or Funct is unsupported
- State  output  4  current state, for debug and bench

Behaviour:
- AluOp encoding (fixed):
  - ADD=0000, SUB=0010, AND=0100, OR=0101, XOR=0110, NOR=0111, SLT=1010.
- Opcodes:
  - R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, ADDI=001000, J=000010.
- Funct codes:
  - add=100000, sub=100010, and=100100, or=100101, xor=100110, nor=100111, slt=101010.
- Reset:
  - RESET_N=0 at a rising edge forces State to FETCH.
  - Applies from any state, mid-instruction included; no partial write completes after the reset edge.
- Outputs are purely combinational from State. Exceptions:
  - AluOp in EXECUTE additionally depends on Funct.
  - PCEn additionally depends on Zero and Op.
  - Illegal additionally depends on Op and Funct.
- Every output not listed for a state is 0. AluOp defaults to ADD.
- States and asserted outputs:
  - FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, AluOp=ADD, PCSrc=00, IRWrite=1, PCEn=1. Next: DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, AluOp=ADD (precomputes branch target). Next by Op:
    - LW/SW -> MEMADR
    - R with legal Funct -> EXECUTE
    - BEQ/BNE -> BRANCH
    - ADDI -> ADDIEX
    - J -> JUMP
    - otherwise -> FETCH with Illegal=1
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ADD. Next: MEMRD if LW, MEMWR if SW.
  - MEMRD(3): IorD=1. Next: MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR(5): IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, AluOp=decode(Funct). Next: ALUWB.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, AluOp=SUB, PCSrc=01. Next: FETCH.
    - PCEn = Zero for BEQ; PCEn = ~Zero for BNE.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ADD. Next: ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - JUMP(11): PCSrc=10, PCEn=1. Next: FETCH.
  - Unused encodings 12-15: all outputs 0; next state FETCH.
- Latency in cycles including FETCH:
  - LW 5; SW, R-type and ADDI 4; BEQ, BNE and J 3; illegal 2.
- Op and Funct are sampled only in DECODE, MEMADR, EXECUTE and BRANCH. They are stable from the FETCH IRWrite until the next FETCH.
- The C (carry) flag is not consumed.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encoding constants
  - opcode and funct constants
  - AluOp encoding constants (also used by the ALU bench)
- One combinational sub-module, mips_alu_decoder:
  - inputs Funct; outputs AluOp[3:0] and FunctValid.
  - Used in DECODE for legality checking and in EXECUTE for AluOp.

Test Plan:
- Reset: RESET_N=0 held 2 cycles from BRANCH state -> State=0 and IRWrite=1 on the first cycle after release; MemWrite=RegWrite=0 throughout.
- LW (Op=100011): 5 cycles. State sequence 0,1,2,3,4. AluOp=0000 in state 2. IorD=1 in state 3. RegWrite=1 and MemtoReg=1 in state 4. Then back to 0.
- R-type sweep (Op=0): one instruction per supported Funct; AluOp in EXECUTE is 0000, 0010, 0100, 0101, 0110, 0111, 1010 respectively. RegDst=1 and RegWrite=1 in ALUWB.
- Branches: BEQ with Zero=1 -> PCEn=1, PCSrc=01 in BRANCH. BEQ with Zero=0 -> PCEn=0. BNE with Zero=0 -> PCEn=1. Each instruction is 3 cycles.
- Illegal: Op=111111, and separately Op=0 with Funct=000000 -> Illegal=1 for exactly one cycle in DECODE, next state FETCH, no RegWrite/MemWrite.
- SW then J back-to-back: SW gives states 0,1,2,5 with MemWrite=1 only in 5. J gives states 0,1,11 with PCSrc=10 and PCEn=1.
